// File: rtl/mem_access_stage.sv
// Memory stage of the RV64 pipeline: turns the EX/MEM memory op into a data-bus
// request, stalls upstream while it is outstanding, and aligns/extends load data.
module mem_access_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic                op_load,
    input  logic                op_store,
    input  logic [2:0]          op_funct3,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic                hold_in,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [2:0]          dreq_size,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_rdata,
    output logic                mem_stall,
    output logic [DATA_W-1:0]   wb_data,
    output logic                misalign
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   resp_reg, resp_next;

    logic                mem_op;
    logic [1:0]          access_size;
    logic [2:0]          lane_off;
    logic [5:0]          lane_shift;
    logic                misaligned;
    logic                issue_idle;
    logic                req_active;
    logic [STRB_W-1:0]   size_mask;
    logic [DATA_W-1:0]   lane_data;
    logic [DATA_W-1:0]   load_value;

    assign mem_op      = op_valid & (op_load | op_store);
    assign access_size = op_funct3[1:0];
    assign lane_off    = op_addr[2:0];
    assign lane_shift  = {lane_off, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (access_size)
            2'd1:    misaligned = op_addr[0];
            2'd2:    misaligned = |op_addr[1:0];
            2'd3:    misaligned = |op_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // One enable per byte covered by the access, before shifting to the lane.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_size_mask
            assign size_mask[gi] = ((32'(gi) >> access_size) == 32'd0);
        end
    endgenerate

    assign issue_idle = (state_reg == IDLE) & mem_op & ~misaligned;
    assign req_active = ~reset & (issue_idle | (state_reg == WAIT));

    // Extraction uses the held op_addr offset; the buffer holds the raw doubleword.
    assign lane_data = resp_reg >> lane_shift;

    always_comb begin
        load_value = '0;
        case (op_funct3)
            3'd0:    load_value = {{(DATA_W-8){lane_data[7]}},   lane_data[7:0]};
            3'd1:    load_value = {{(DATA_W-16){lane_data[15]}}, lane_data[15:0]};
            3'd2:    load_value = {{(DATA_W-32){lane_data[31]}}, lane_data[31:0]};
            3'd3:    load_value = lane_data;
            3'd4:    load_value = {{(DATA_W-8){1'b0}},  lane_data[7:0]};
            3'd5:    load_value = {{(DATA_W-16){1'b0}}, lane_data[15:0]};
            3'd6:    load_value = {{(DATA_W-32){1'b0}}, lane_data[31:0]};
            default: load_value = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        resp_next  = resp_reg;
        case (state_reg)
            IDLE: begin
                if (issue_idle) begin
                    if (dresp_data_ok) begin
                        resp_next  = dresp_rdata;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    resp_next  = dresp_rdata;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!hold_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            resp_reg  <= '0;
        end else begin
            state_reg <= state_next;
            resp_reg  <= resp_next;
        end
    end

    // Outputs are combinational from state and the frozen EX/MEM inputs, forced low in reset.
    always_comb begin
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = 3'd0;
        dreq_strobe = '0;
        dreq_data   = '0;
        mem_stall   = 1'b0;
        wb_data     = '0;
        misalign    = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (!mem_op) begin
                        wb_data = DATA_W'(op_addr);
                    end else if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                WAIT: mem_stall = 1'b1;
                DONE: begin
                    if (op_load) begin
                        wb_data = load_value;
                    end
                end
                default: ;
            endcase
            if (req_active) begin
                dreq_valid = 1'b1;
                dreq_addr  = op_addr;
                dreq_size  = {1'b0, access_size};
                dreq_data  = op_wdata << lane_shift;
                if (op_store) begin
                    dreq_strobe = size_mask << lane_off;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed test-plan scenarios plus randomized
// loads/stores checked against a byte-lane arithmetic model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_load, op_store;
    logic [2:0]  op_funct3;
    logic [63:0] op_addr, op_wdata;
    logic        hold_in;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_rdata;
    logic        mem_stall;
    logic [63:0] wb_data;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_load       (op_load),
        .op_store      (op_store),
        .op_funct3     (op_funct3),
        .op_addr       (op_addr),
        .op_wdata      (op_wdata),
        .hold_in       (hold_in),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_rdata   (dresp_rdata),
        .mem_stall     (mem_stall),
        .wb_data       (wb_data),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    // Runs one memory op: request phase (waitc cycles before data_ok), then DONE
    // for holdc+1 cycles, then one non-memory cycle. Expectations come from byte-lane arithmetic.
    task automatic do_mem(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata, input int waitc,
                          input int holdc, output logic [63:0] wb_seen, output int stalls,
                          output logic [7:0] strb_seen, output logic [63:0] data_seen);
        int          bytes;
        int          off;
        bit          mis;
        logic [15:0] wide;
        logic [7:0]  e_strb;
        logic [63:0] e_data, e_wb, mask, lane, idle_addr;
        int          e_stalls;
        bytes = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        mis   = (addr % 64'(bytes)) != 64'd0;
        wide  = ((16'd1 << bytes) - 16'd1) << off;
        e_strb = st ? wide[7:0] : 8'h00;
        e_data = wdata << (8 * off);
        mask   = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
        lane   = (rdata >> (8 * off)) & mask;
        if (f3 < 3'd3 && lane[8 * bytes - 1]) lane = lane | ~mask;
        e_wb     = (mis || !ld) ? 64'd0 : lane;
        e_stalls = mis ? 0 : waitc + 1;
        stalls = 0; wb_seen = '0; strb_seen = '0; data_seen = '0;
        $display("txn %s f3=%0d addr=%h wdata=%h rdata=%h wait=%0d hold=%0d expect_wb=%h mis=%0d",
                 ld ? "LOAD " : "STORE", f3, addr, wdata, rdata, waitc, holdc, e_wb, mis);
        for (int c = 0; c <= (mis ? 0 : waitc); c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                op_valid = 1'b1; op_load = ld; op_store = st; op_funct3 = f3;
                op_addr = addr; op_wdata = wdata; dresp_rdata = rdata; hold_in = 1'b0;
            end
            dresp_data_ok = !mis && (c == waitc);
            #1;
            if (mem_stall) stalls++;
            if (mis) begin
                n_cmp++;
                if ({misalign, dreq_valid, mem_stall} !== 3'b100 || wb_data !== 64'd0) begin
                    n_err++;
                    $display("FAIL misalign_cycle: got mis=%b req=%b stall=%b wb=%h expected 1 0 0 0",
                             misalign, dreq_valid, mem_stall, wb_data);
                end
                wb_seen = wb_data;
            end else begin
                n_cmp++;
                if ({dreq_valid, mem_stall, misalign} !== 3'b110) begin
                    n_err++;
                    $display("FAIL request_ctrl c=%0d: got req=%b stall=%b mis=%b expected 1 1 0",
                             c, dreq_valid, mem_stall, misalign);
                end
                n_cmp++;
                if (dreq_addr !== addr || dreq_size !== {1'b0, f3[1:0]}) begin
                    n_err++;
                    $display("FAIL request_addr c=%0d: got %h/%0d expected %h/%0d",
                             c, dreq_addr, dreq_size, addr, f3[1:0]);
                end
                n_cmp++;
                if (dreq_strobe !== e_strb || (st && dreq_data !== e_data)) begin
                    n_err++;
                    $display("FAIL request_lane c=%0d: got strb=%h data=%h expected strb=%h data=%h",
                             c, dreq_strobe, dreq_data, e_strb, e_data);
                end
                if (c == 0) begin strb_seen = dreq_strobe; data_seen = dreq_data; end
            end
        end
        if (!mis) begin
            for (int h = 0; h <= holdc; h++) begin
                @(posedge clk); #1;
                dresp_data_ok = 1'b0;
                dresp_rdata   = {$urandom, $urandom};
                hold_in       = (h < holdc);
                #1;
                if (mem_stall) stalls++;
                n_cmp++;
                if (dreq_valid !== 1'b0 || mem_stall !== 1'b0 || wb_data !== e_wb) begin
                    n_err++;
                    $display("FAIL done_cycle h=%0d: got req=%b stall=%b wb=%h expected 0 0 %h",
                             h, dreq_valid, mem_stall, wb_data, e_wb);
                end
                wb_seen = wb_data;
            end
        end
        n_cmp++;
        if (stalls !== e_stalls) begin
            n_err++;
            $display("FAIL stall_count: got %0d expected %0d", stalls, e_stalls);
        end
        // Non-memory cycle: address passes through, stray data_ok is ignored.
        @(posedge clk); #1;
        idle_addr = {$urandom, $urandom};
        op_valid = 1'($urandom); op_load = op_valid ? 1'b0 : 1'($urandom); op_store = 1'b0;
        op_addr = idle_addr; hold_in = 1'b0; dresp_data_ok = 1'($urandom);
        #1;
        n_cmp++;
        if (dreq_valid !== 1'b0 || mem_stall !== 1'b0 || misalign !== 1'b0 || wb_data !== idle_addr) begin
            n_err++;
            $display("FAIL idle_cycle: got req=%b stall=%b mis=%b wb=%h expected 0 0 0 %h",
                     dreq_valid, mem_stall, misalign, wb_data, idle_addr);
        end
        dresp_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_funct3 = 3'd3;
        op_addr = 64'h100; op_wdata = 64'h1234; hold_in = 1'b0; dresp_data_ok = 1'b1;
        dresp_rdata = 64'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            n_cmp++;
            if ({dreq_valid, mem_stall, misalign} !== 3'b000 || dreq_addr !== 64'd0 ||
                dreq_strobe !== 8'd0 || dreq_data !== 64'd0 || dreq_size !== 3'd0 || wb_data !== 64'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got req=%b stall=%b mis=%b addr=%h wb=%h expected all 0",
                         dreq_valid, mem_stall, misalign, dreq_addr, wb_data);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0; dresp_data_ok = 1'b0; op_addr = 64'hCAFE_0000_0000_0042;
        #1;
        n_cmp++;
        if (dreq_valid !== 1'b0 || mem_stall !== 1'b0 || wb_data !== 64'hCAFE_0000_0000_0042) begin
            n_err++;
            $display("FAIL post_reset_idle: got req=%b stall=%b wb=%h expected 0 0 cafe000000000042",
                     dreq_valid, mem_stall, wb_data);
        end
    endtask

    task automatic test_lw_wait();
        logic [63:0] wb; int st; logic [7:0] sb; logic [63:0] sd;
        do_mem(1, 0, 3'd2, 64'h1004, 64'd0, 64'h8000_0001_1234_5678, 2, 0, wb, st, sb, sd);
        n_cmp++;
        if (wb !== 64'hFFFF_FFFF_8000_0001 || st !== 3) begin
            n_err++;
            $display("FAIL lw_wait: got wb=%h stalls=%0d expected ffffffff80000001 3", wb, st);
        end
    endtask

    task automatic test_lbu_fast();
        logic [63:0] wb; int st; logic [7:0] sb; logic [63:0] sd;
        do_mem(1, 0, 3'd4, 64'h2003, 64'd0, 64'h0000_0000_AB00_0000, 0, 0, wb, st, sb, sd);
        n_cmp++;
        if (wb !== 64'hAB || st !== 1) begin
            n_err++;
            $display("FAIL lbu_fast: got wb=%h stalls=%0d expected ab 1", wb, st);
        end
    endtask

    task automatic test_sh_lane();
        logic [63:0] wb; int st; logic [7:0] sb; logic [63:0] sd;
        do_mem(0, 1, 3'd1, 64'h3006, 64'hBEEF, 64'h5555, 1, 0, wb, st, sb, sd);
        n_cmp++;
        if (sb !== 8'hC0 || sd !== 64'hBEEF_0000_0000_0000 || wb !== 64'd0) begin
            n_err++;
            $display("FAIL sh_lane: got strb=%h data=%h wb=%h expected c0 beef000000000000 0", sb, sd, wb);
        end
    endtask

    task automatic test_ld_misalign();
        logic [63:0] wb; int st; logic [7:0] sb; logic [63:0] sd;
        do_mem(1, 0, 3'd3, 64'h4004, 64'd0, 64'h1111, 0, 0, wb, st, sb, sd);
        n_cmp++;
        if (st !== 0 || wb !== 64'd0) begin
            n_err++;
            $display("FAIL ld_misalign: got stalls=%0d wb=%h expected 0 0", st, wb);
        end
    endtask

    task automatic test_hold_done();
        logic [63:0] wb; int st; logic [7:0] sb; logic [63:0] sd;
        do_mem(1, 0, 3'd3, 64'h4000, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 2, wb, st, sb, sd);
        n_cmp++;
        if (wb !== 64'h0123_4567_89AB_CDEF || st !== 2) begin
            n_err++;
            $display("FAIL hold_done: got wb=%h stalls=%0d expected 0123456789abcdef 2", wb, st);
        end
    endtask

    task automatic test_reset_wait();
        $display("txn LOAD  reset-in-WAIT at addr=0000000000005000");
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_funct3 = 3'd2;
        op_addr = 64'h5000; dresp_data_ok = 1'b0; hold_in = 1'b0;
        @(posedge clk); #2;
        n_cmp++;
        if (dreq_valid !== 1'b1 || mem_stall !== 1'b1) begin
            n_err++;
            $display("FAIL wait_before_reset: got req=%b stall=%b expected 1 1", dreq_valid, mem_stall);
        end
        @(posedge clk); #1; reset = 1'b1; #1;
        n_cmp++;
        if ({dreq_valid, mem_stall, misalign} !== 3'b000 || dreq_addr !== 64'd0 || wb_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_in_wait: got req=%b stall=%b addr=%h wb=%h expected all 0",
                     dreq_valid, mem_stall, dreq_addr, wb_data);
        end
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_addr = 64'd0; op_wdata = 64'd0;
        #1;
        n_cmp++;
        if ({dreq_valid, mem_stall, misalign} !== 3'b000 || wb_data !== 64'd0) begin
            n_err++;
            $display("FAIL after_reset_wait: got req=%b stall=%b wb=%h expected 0 0 0",
                     dreq_valid, mem_stall, wb_data);
        end
        @(posedge clk); #1; dresp_data_ok = 1'b1; dresp_rdata = 64'hBAD0_BAD0_BAD0_BAD0; #1;
        n_cmp++;
        if ({dreq_valid, mem_stall} !== 2'b00 || wb_data !== 64'd0) begin
            n_err++;
            $display("FAIL late_data_ok: got req=%b stall=%b wb=%h expected 0 0 0",
                     dreq_valid, mem_stall, wb_data);
        end
        @(posedge clk); #1;
        dresp_data_ok = 1'b0; op_valid = 1'b1; op_load = 1'b1; op_funct3 = 3'd4; op_addr = 64'h10;
        #1;
        n_cmp++;
        if (dreq_valid !== 1'b1 || mem_stall !== 1'b1) begin
            n_err++;
            $display("FAIL fresh_request: got req=%b stall=%b expected 1 1", dreq_valid, mem_stall);
        end
        @(posedge clk); #1; dresp_data_ok = 1'b1; dresp_rdata = 64'h0000_0000_0000_0077;
        @(posedge clk); #1; dresp_data_ok = 1'b0; #1;
        n_cmp++;
        if (wb_data !== 64'h77 || mem_stall !== 1'b0) begin
            n_err++;
            $display("FAIL fresh_result: got wb=%h stall=%b expected 77 0", wb_data, mem_stall);
        end
        @(posedge clk); #1; op_valid = 1'b0; op_load = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] wb; int st; logic [7:0] sb; logic [63:0] sd;
        bit ld; logic [2:0] f3; logic [63:0] addr; int bytes;
        for (int i = 0; i < 40; i++) begin
            ld    = 1'($urandom);
            f3    = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            bytes = 1 << f3[1:0];
            addr  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(bytes - 1);
            do_mem(ld, !ld, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 2), wb, st, sb, sd);
        end
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_lbu_fast();
        test_sh_lane();
        test_ld_misalign();
        test_hold_done();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
